// File: rtl/ip_tx_arbiter_if.sv
// Signal bundle between the ICMP/UDP requesters, the arbiter and the IP transmitter.
// The slave view belongs to the arbiter; the master view drives the requester and IP-TX side.
interface ip_tx_arbiter_if;
    logic        icmp_req;
    logic        udp_req;
    logic        icmp_ack;
    logic        udp_ack;
    logic        icmp_done;
    logic        udp_done;
    logic [15:0] icmp_length;
    logic [15:0] udp_length;
    logic [7:0]  icmp_type;
    logic [7:0]  udp_type;
    logic [7:0]  icmp_data;
    logic [7:0]  udp_data;
    logic        icmp_tx_ready;
    logic        udp_tx_ready;
    logic        icmp_data_req;
    logic        udp_data_req;
    logic        ip_tx_req;
    logic        ip_tx_ack;
    logic        ip_tx_end;
    logic        upper_data_req;
    logic [15:0] ip_send_data_length;
    logic [7:0]  ip_send_type;
    logic [7:0]  upper_layer_data;
    logic        upper_tx_ready;

    modport slave (
        input  icmp_req, udp_req,
        input  icmp_length, udp_length,
        input  icmp_type, udp_type,
        input  icmp_data, udp_data,
        input  icmp_tx_ready, udp_tx_ready,
        input  ip_tx_ack, ip_tx_end, upper_data_req,
        output icmp_ack, udp_ack,
        output icmp_done, udp_done,
        output icmp_data_req, udp_data_req,
        output ip_tx_req,
        output ip_send_data_length, ip_send_type,
        output upper_layer_data, upper_tx_ready
    );

    modport master (
        output icmp_req, udp_req,
        output icmp_length, udp_length,
        output icmp_type, udp_type,
        output icmp_data, udp_data,
        output icmp_tx_ready, udp_tx_ready,
        output ip_tx_ack, ip_tx_end, upper_data_req,
        input  icmp_ack, udp_ack,
        input  icmp_done, udp_done,
        input  icmp_data_req, udp_data_req,
        input  ip_tx_req,
        input  ip_send_data_length, ip_send_type,
        input  upper_layer_data, upper_tx_ready
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one IP transmitter between ICMP and UDP,
// with ack/end timeouts and an enforced inter-frame gap.
module ip_tx_arbiter #(
    parameter int unsigned GAP_CYCLES  = 12,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF,
    parameter logic [15:0] END_TIMEOUT = 16'hFFFF
) (
    input logic            clk,
    input logic            rstn,
    ip_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_e;

    localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES);

    state_e      state_q;
    logic        last_q;
    logic        grant_q;
    logic        tx_req_q;
    logic        icmp_ack_q;
    logic        udp_ack_q;
    logic        icmp_done_q;
    logic        udp_done_q;
    logic [15:0] cnt_q;
    logic [15:0] len_q;
    logic [7:0]  type_q;

    logic        any_req;
    logic        win_d;
    logic [15:0] cnt_inc;
    logic        active;

    assign any_req = bus.icmp_req | bus.udp_req;
    // 0 = ICMP, 1 = UDP; on contention the side not served last wins
    assign win_d   = (bus.icmp_req & bus.udp_req) ? ~last_q : bus.udp_req;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign active  = (state_q == GRANT) || (state_q == BUSY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            tx_req_q    <= 1'b0;
            icmp_ack_q  <= 1'b0;
            udp_ack_q   <= 1'b0;
            icmp_done_q <= 1'b0;
            udp_done_q  <= 1'b0;
            cnt_q       <= 16'd0;
            len_q       <= 16'd0;
            type_q      <= 8'd0;
        end else begin
            icmp_ack_q  <= 1'b0;
            udp_ack_q   <= 1'b0;
            icmp_done_q <= 1'b0;
            udp_done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= GRANT;
                        grant_q  <= win_d;
                        tx_req_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        len_q    <= win_d ? bus.udp_length : bus.icmp_length;
                        type_q   <= win_d ? bus.udp_type : bus.icmp_type;
                    end
                end
                GRANT: begin
                    if (bus.ip_tx_ack) begin
                        state_q    <= BUSY;
                        tx_req_q   <= 1'b0;
                        cnt_q      <= 16'd0;
                        icmp_ack_q <= ~grant_q;
                        udp_ack_q  <= grant_q;
                    end else if (cnt_inc >= ACK_TIMEOUT) begin
                        state_q     <= GAP;
                        tx_req_q    <= 1'b0;
                        cnt_q       <= 16'd0;
                        icmp_done_q <= ~grant_q;
                        udp_done_q  <= grant_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                BUSY: begin
                    if (bus.ip_tx_end || cnt_inc >= END_TIMEOUT) begin
                        state_q     <= GAP;
                        cnt_q       <= 16'd0;
                        last_q      <= grant_q;
                        icmp_done_q <= ~grant_q;
                        udp_done_q  <= grant_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt_inc >= GAP_LIM) begin
                        state_q <= IDLE;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ip_tx_req           = tx_req_q;
    assign bus.icmp_ack            = icmp_ack_q;
    assign bus.udp_ack             = udp_ack_q;
    assign bus.icmp_done           = icmp_done_q;
    assign bus.udp_done            = udp_done_q;
    assign bus.ip_send_data_length = len_q;
    assign bus.ip_send_type        = type_q;

    assign bus.upper_layer_data = !active ? 8'd0
                                : (grant_q ? bus.udp_data : bus.icmp_data);
    assign bus.upper_tx_ready   = active
                                & (grant_q ? bus.udp_tx_ready : bus.icmp_tx_ready);
    assign bus.icmp_data_req    = (state_q == BUSY) & ~grant_q & bus.upper_data_req;
    assign bus.udp_data_req     = (state_q == BUSY) & grant_q & bus.upper_data_req;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: single grant, ack timeout, round-robin,
// payload routing, mid-frame reset and ack/end collision.
module tb_ip_tx_arbiter;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ip_tx_arbiter_if bus ();

    ip_tx_arbiter #(
        .GAP_CYCLES (12),
        .ACK_TIMEOUT(16'd16),
        .END_TIMEOUT(16'd16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int w);
        w = 0;
        while (!bus.ip_tx_req && w < 40) begin
            cyc(1);
            w++;
        end
        check("wait_req", bus.ip_tx_req, 1);
    endtask

    task automatic frame(input logic exp_udp, input bit chk_gap);
        int w;
        wait_req(w);
        if (chk_gap) check("gap_len", w, 13);
        check("grant_len", bus.ip_send_data_length, exp_udp ? 200 : 60);
        check("grant_type", bus.ip_send_type, exp_udp ? 17 : 1);
        bus.ip_tx_ack = 1'b1;
        cyc(1);
        bus.ip_tx_ack = 1'b0;
        #1;
        check("ack_icmp", bus.icmp_ack, !exp_udp);
        check("ack_udp", bus.udp_ack, exp_udp);
        check("busy_req", bus.ip_tx_req, 0);
        bus.upper_data_req = 1'b1;
        #1;
        check("dreq_icmp", bus.icmp_data_req, !exp_udp);
        check("dreq_udp", bus.udp_data_req, exp_udp);
        check("ul_data", bus.upper_layer_data, exp_udp ? 8'hA5 : 8'h3C);
        check("ul_ready", bus.upper_tx_ready, !exp_udp);
        bus.upper_data_req = 1'b0;
        bus.ip_tx_end = 1'b1;
        cyc(1);
        bus.ip_tx_end = 1'b0;
        check("done_icmp", bus.icmp_done, !exp_udp);
        check("done_udp", bus.udp_done, exp_udp);
        check("gap_data", bus.upper_layer_data, 0);
    endtask

    initial begin
        int w;
        rstn               = 1'b0;
        bus.icmp_req       = 1'b0;
        bus.udp_req        = 1'b0;
        bus.icmp_length    = 16'd60;
        bus.icmp_type      = 8'd1;
        bus.udp_length     = 16'd200;
        bus.udp_type       = 8'd17;
        bus.icmp_data      = 8'h3C;
        bus.udp_data       = 8'hA5;
        bus.icmp_tx_ready  = 1'b1;
        bus.udp_tx_ready   = 1'b0;
        bus.ip_tx_ack      = 1'b0;
        bus.ip_tx_end      = 1'b0;
        bus.upper_data_req = 1'b0;
        cyc(2);
        check("rst_req", bus.ip_tx_req, 0);
        check("rst_len", bus.ip_send_data_length, 0);
        check("rst_type", bus.ip_send_type, 0);
        check("rst_pulses", {bus.icmp_ack, bus.udp_ack, bus.icmp_done, bus.udp_done}, 0);
        check("rst_ul", bus.upper_layer_data, 0);
        rstn = 1'b1;
        cyc(1);

        // Single ICMP request, ack after a few GRANT cycles, then end
        bus.icmp_req = 1'b1;
        cyc(1);
        check("t1_req", bus.ip_tx_req, 1);
        check("t1_len", bus.ip_send_data_length, 60);
        check("t1_type", bus.ip_send_type, 1);
        bus.icmp_req = 1'b0;
        cyc(3);
        check("t1_req_hold", bus.ip_tx_req, 1);
        check("t1_no_ack", bus.icmp_ack, 0);
        bus.ip_tx_ack = 1'b1;
        cyc(1);
        bus.ip_tx_ack = 1'b0;
        check("t1_ack", bus.icmp_ack, 1);
        check("t1_busy_req", bus.ip_tx_req, 0);
        cyc(1);
        check("t1_ack_once", bus.icmp_ack, 0);
        bus.ip_tx_end = 1'b1;
        cyc(1);
        bus.ip_tx_end = 1'b0;
        check("t1_done", bus.icmp_done, 1);
        check("t1_len_stable", bus.ip_send_data_length, 60);
        bus.udp_req = 1'b1;
        cyc(11);
        check("t1_gap_hold", bus.ip_tx_req, 0);
        check("t1_done_once", bus.icmp_done, 0);
        cyc(1);
        check("t1_gap_idle", bus.ip_tx_req, 0);
        cyc(1);
        check("t1_next_req", bus.ip_tx_req, 1);
        check("t1_next_len", bus.ip_send_data_length, 200);

        // UDP granted, no ack: timeout after 16 GRANT cycles
        bus.udp_req = 1'b0;
        cyc(15);
        check("t2_still_grant", bus.ip_tx_req, 1);
        check("t2_no_done", bus.udp_done, 0);
        check("t2_no_ack", bus.udp_ack, 0);
        cyc(1);
        check("t2_done", bus.udp_done, 1);
        check("t2_req_off", bus.ip_tx_req, 0);
        check("t2_no_ack2", bus.udp_ack, 0);
        cyc(1);
        check("t2_done_once", bus.udp_done, 0);

        // Both held: ack timeout left last grant at ICMP, so UDP leads
        bus.icmp_req = 1'b1;
        bus.udp_req  = 1'b1;
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b1);
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b1);

        // Reset in BUSY: outputs clear at once, ICMP wins afterwards
        wait_req(w);
        bus.ip_tx_ack = 1'b1;
        cyc(1);
        bus.ip_tx_ack = 1'b0;
        check("t4_ack", bus.udp_ack, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t4_rst_ack", bus.udp_ack, 0);
        check("t4_rst_len", bus.ip_send_data_length, 0);
        check("t4_rst_type", bus.ip_send_type, 0);
        check("t4_rst_ul", bus.upper_layer_data, 0);
        check("t4_rst_ready", bus.upper_tx_ready, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("t4_no_done", {bus.icmp_done, bus.udp_done}, 0);
        frame(1'b0, 1'b0);

        // Ack and end together: end ignored, END_TIMEOUT recovers
        wait_req(w);
        check("t5_len", bus.ip_send_data_length, 200);
        bus.ip_tx_ack = 1'b1;
        bus.ip_tx_end = 1'b1;
        cyc(1);
        bus.ip_tx_ack = 1'b0;
        bus.ip_tx_end = 1'b0;
        check("t5_ack", bus.udp_ack, 1);
        cyc(15);
        check("t5_end_ignored", bus.udp_done, 0);
        check("t5_busy_data", bus.upper_layer_data, 8'hA5);
        cyc(1);
        check("t5_timeout_done", bus.udp_done, 1);
        bus.icmp_req = 1'b0;
        bus.udp_req  = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 12: idle cycles enforced between consecutive grants.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16'hFFFF: GRANT cycles without ip_tx_ack before abort.
REQ-003 SHALL have parameter END_TIMEOUT, default 16'hFFFF: BUSY cycles without ip_tx_end before abort.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports icmp_req / udp_req, input, 1 each: level request from each requester.
REQ-007 SHALL have ports icmp_ack / udp_ack, output, 1 each: one-cycle grant-accepted pulse.
REQ-008 SHALL have ports icmp_done / udp_done, output, 1 each: one-cycle completion or abort pulse.
REQ-009 SHALL have ports icmp_length / udp_length, input, 16 each: IP total length.
REQ-010 SHALL have ports icmp_type / udp_type, input, 8 each: IP protocol field.
REQ-011 SHALL have ports icmp_data / udp_data, input, 8 each: payload byte from each requester.
REQ-012 SHALL have ports icmp_tx_ready / udp_tx_ready, input, 1 each: payload ready from each requester.
REQ-013 SHALL have ports icmp_data_req / udp_data_req, output, 1 each: routed payload request.
REQ-014 SHALL have port ip_tx_req, output, 1: request to the IP transmitter.
REQ-015 SHALL have port ip_tx_ack, input, 1: acknowledge from the IP transmitter.
REQ-016 SHALL have port ip_tx_end, input, 1: end-of-frame pulse from the IP transmitter.
REQ-017 SHALL have port upper_data_req, input, 1: payload request from the IP transmitter.
REQ-018 SHALL have ports ip_send_data_length (16), ip_send_type (8), upper_layer_data (8) and upper_tx_ready (1), all outputs: muxed toward the IP transmitter.

Function
REQ-019 SHALL implement a FSM with states IDLE, GRANT, BUSY and GAP; the reset state SHALL be IDLE.
REQ-020 IDLE: SHALL move to GRANT on any request. It SHALL register the winner's length and type into ip_send_data_length and ip_send_type on that edge.
REQ-021 Arbitration SHALL be round-robin via a 1-bit last_grant register (reset value 1 = UDP, so ICMP wins first). Simultaneous requests SHALL go to the requester not served last. A single request SHALL always win.
REQ-022 GRANT: ip_tx_req SHALL be 1. The first cycle with ip_tx_ack=1 SHALL pulse the winner's *_ack for one cycle, then go to BUSY.
REQ-023 GRANT: a counter SHALL count cycles without ack. When it reaches ACK_TIMEOUT, the block SHALL pulse the winner's *_done and go to GAP.
REQ-024 BUSY: ip_tx_req SHALL be 0. On ip_tx_end=1 the block SHALL pulse the winner's *_done, update last_grant to the winner, and go to GAP.
REQ-025 BUSY: if END_TIMEOUT cycles pass without ip_tx_end, the block SHALL pulse *_done, update last_grant, and go to GAP.
REQ-026 GAP: the block SHALL count GAP_CYCLES cycles, then go to IDLE. Requests SHALL be ignored during GAP.
REQ-027 The timeout counters SHALL be 16 bits, clear on every state entry, and saturate with no wrap-around.
REQ-028 upper_layer_data and upper_tx_ready SHALL be combinational muxes on the registered grant, valid in GRANT and BUSY. Outside those states they SHALL be 0.
REQ-029 upper_data_req SHALL be routed combinationally only to the granted requester in BUSY. The other requester's *_data_req SHALL be held at 0.
REQ-030 ip_send_data_length and ip_send_type SHALL stay stable from the IDLE->GRANT edge until the next grant.
REQ-031 If a requester drops *_req while in GRANT or BUSY, the transaction SHALL still complete, and *_done SHALL still pulse.
REQ-032 ip_tx_ack and ip_tx_end arriving in the same GRANT cycle: the block SHALL pulse *_ack and go to BUSY. The end SHALL be ignored, and END_TIMEOUT SHALL cover recovery.
REQ-033 Latency from request to ip_tx_req SHALL be exactly 1 cycle from IDLE.

Reset
REQ-034 On rstn=0, asynchronously: state=IDLE, last_grant=1, counters=0, and all outputs 0, including ip_send_data_length=16'd0 and ip_send_type=8'd0.
REQ-035 Reset deasserted mid-frame SHALL restart in IDLE without any *_ack or *_done pulse.

Verification
REQ-036 icmp_req=1 alone, icmp_length=16'd60, icmp_type=8'd1 -> next cycle ip_tx_req=1, ip_send_data_length=60, ip_send_type=1. Ack at cycle 5 -> icmp_ack pulses once. ip_tx_end -> icmp_done pulses, then 12 GAP cycles follow.
REQ-037 Both requests held continuously -> grants alternate ICMP, UDP, ICMP, UDP over 4 frames, with GAP_CYCLES idle between frames.
REQ-038 udp_req=1 and ip_tx_ack never asserted, with ACK_TIMEOUT=16 -> udp_done pulses after 16 GRANT cycles, udp_ack is never 1, and the FSM returns to IDLE.
REQ-039 UDP granted and upper_data_req pulsed -> udp_data_req=1 that cycle and icmp_data_req=0. upper_layer_data equals udp_data (e.g. 8'hA5).
REQ-040 rstn pulsed low during BUSY -> all outputs 0 immediately (asynchronously), and the next grant goes to ICMP when both requests are active.
